dffram_bist: RTL and testbench

Built-in self-test engine placed directly upstream of the 128×8 DFF RAM macro. Drives the RAM's address/write-enable/write-data port and consumes its read data. Runs a March C- sequence over the whole array on request, then reports pass/fail with the first failing address and data. A top-level mux uses `ram_sel` to hand the RAM port to this block while it runs.

---
 rtl/dffram_bist_pkg.sv | 46 ++++
 rtl/dffram_bist_if.sv | 21 ++
 rtl/dffram_bist_addr_gen.sv | 26 ++
 rtl/dffram_bist.sv | 158 +++++++++++++++
 tb/tb_dffram_bist.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dffram_bist_pkg.sv
// Shared types and the March C- element table for the DFF RAM BIST engine.
// Direction and read/write patterns of each element live here so the FSM stays table-driven.
package dffram_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StWait,
        StCheck,
        StFinish
    } state_e;

    typedef enum logic [2:0] {
        ElemM0,
        ElemM1,
        ElemM2,
        ElemM3,
        ElemM4,
        ElemM5
    } elem_e;

    typedef enum logic [1:0] {
        PatNone,
        PatBg,
        PatInv
    } pat_sel_e;

    typedef struct packed {
        logic     down;
        pat_sel_e rd;
        pat_sel_e wr;
    } elem_cfg_t;

    localparam int unsigned NUM_ELEMS = 6;

    localparam elem_cfg_t ELEM_TABLE [NUM_ELEMS] = '{
        '{down: 1'b0, rd: PatNone, wr: PatBg },
        '{down: 1'b0, rd: PatBg,   wr: PatInv},
        '{down: 1'b0, rd: PatInv,  wr: PatBg },
        '{down: 1'b1, rd: PatBg,   wr: PatInv},
        '{down: 1'b1, rd: PatInv,  wr: PatBg },
        '{down: 1'b1, rd: PatBg,   wr: PatNone}
    };

endpackage

// File: rtl/dffram_bist_if.sv
// RAM-side port of the BIST engine: address/write bus out, read data back.
interface dffram_bist_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
);
    logic              ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_sel, ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_sel, ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dffram_bist_addr_gen.sv
// Up/down address counter for the march walk; wraps naturally between elements.
module dffram_bist_addr_gen #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_first,
    input  logic              step,
    input  logic              dir,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load_first) begin
            addr <= dir ? '1 : '0;
        end else if (step) begin
            addr <= dir ? addr - 1'b1 : addr + 1'b1;
        end
    end

    assign last = dir ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/dffram_bist.sv
// March C- BIST engine for the DFF RAM macro; reports pass/fail and the first failing cell.
// The FSM owns element sequencing; the address walk is delegated to dffram_bist_addr_gen.
module dffram_bist
    import dffram_bist_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 7,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] BG         = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem,
    dffram_bist_if.master     ram
);

    state_e            state_q, adv_state;
    elem_e             elem_q, elem_nxt;
    elem_cfg_t         cfg, nxt_cfg;
    logic [1:0]        wait_q;
    logic              pass_q, fail_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;
    logic [2:0]        fail_elem_q;
    logic [ADDR_W-1:0] addr;
    logic              addr_last, last_elem, match, advance, we;
    logic              load_first, step, gen_dir;
    logic [DATA_W-1:0] exp_data, wr_data;

    function automatic logic [DATA_W-1:0] pat(input pat_sel_e sel);
        return (sel == PatInv) ? ~BG : BG;
    endfunction

    assign cfg       = ELEM_TABLE[elem_q];
    assign last_elem = (elem_q == ElemM5);
    assign elem_nxt  = last_elem ? elem_q : elem_e'(elem_q + 3'd1);
    assign nxt_cfg   = ELEM_TABLE[elem_nxt];
    assign exp_data  = pat(cfg.rd);
    assign wr_data   = pat(cfg.wr);
    assign match     = (ram.ram_rdata == exp_data);
    assign advance   = (state_q == StWrite) || ((state_q == StCheck) && match);

    // Same-direction element boundaries reuse the wrap; a direction change holds the address.
    assign load_first = (state_q == StIdle) && start;
    assign gen_dir    = (state_q == StIdle) ? ELEM_TABLE[ElemM0].down : cfg.down;
    assign step       = advance && (!addr_last || (!last_elem && (nxt_cfg.down == cfg.down)));

    dffram_bist_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_first(load_first),
        .step      (step),
        .dir       (gen_dir),
        .addr      (addr),
        .last      (addr_last)
    );

    always_comb begin
        if (!addr_last) begin
            adv_state = (cfg.rd == PatNone) ? StWrite : StRead;
        end else if (last_elem) begin
            adv_state = StFinish;
        end else begin
            adv_state = (nxt_cfg.rd == PatNone) ? StWrite : StRead;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            elem_q      <= ElemM0;
            wait_q      <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        fail_elem_q <= '0;
                        elem_q      <= ElemM0;
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                end
                StRead: begin
                    if (RD_LATENCY > 1) begin
                        wait_q  <= 2'(RD_LATENCY - 2);
                        state_q <= StWait;
                    end else begin
                        state_q <= StCheck;
                    end
                end
                StWait: begin
                    if (wait_q == '0) begin
                        state_q <= StCheck;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                StCheck: begin
                    if (!match) begin
                        fail_q      <= 1'b1;
                        fail_addr_q <= addr;
                        fail_data_q <= ram.ram_rdata;
                        fail_elem_q <= elem_q;
                        state_q     <= StFinish;
                    end
                end
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
            if (advance) begin
                state_q <= adv_state;
                if (addr_last && !last_elem) begin
                    elem_q <= elem_nxt;
                end
                if (addr_last && last_elem) begin
                    pass_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = state_q inside {StWrite, StRead, StWait, StCheck};
    assign done      = (state_q == StFinish);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_elem = fail_elem_q;

    // CHECK folds the write-back into the compare cycle when the read matched.
    assign we = (state_q == StWrite) ||
                ((state_q == StCheck) && match && (cfg.wr != PatNone));

    assign ram.ram_sel   = busy;
    assign ram.ram_addr  = busy ? addr : '0;
    assign ram.ram_we    = we;
    assign ram.ram_wdata = we ? wr_data : '0;

endmodule

// File: tb/tb_dffram_bist.sv
// Scoreboarded bench for dffram_bist: faulty behavioural RAMs, a March C- reference model,
// and a negedge monitor that checks each done pulse against the queued expectation.
module tb_dffram_bist;

    localparam int DEPTH = 128;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [2:0]  elem;
        logic [31:0] cycles;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start1, start2;
    logic       busy1, done1, pass1, fail1, busy2, done2, pass2, fail2;
    logic [6:0] fa1, fa2;
    logic [7:0] fd1, fd2;
    logic [2:0] fe1, fe2;

    dffram_bist_if #(.ADDR_W(7), .DATA_W(8)) bus1 ();
    dffram_bist_if #(.ADDR_W(7), .DATA_W(8)) bus2 ();

    dffram_bist #(.ADDR_W(7), .DATA_W(8), .RD_LATENCY(1), .BG(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail(fail1), .fail_addr(fa1), .fail_data(fd1), .fail_elem(fe1), .ram(bus1.master)
    );

    dffram_bist #(.ADDR_W(7), .DATA_W(8), .RD_LATENCY(2), .BG(8'h5A)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .fail(fail2), .fail_addr(fa2), .fail_data(fd2), .fail_elem(fe2), .ram(bus2.master)
    );

    // mem[0]/mem[1]: RAMs behind dut1/dut2; mem[2]: reference model array.
    logic [7:0] mem [3][DEPTH];
    int fkind = 0;  // 0 none, 1 stuck-at, 2 coupling
    int f_addr, f_bit, f_val, f_vic;
    int rd_sel [6] = '{0, 1, 2, 1, 2, 1};  // 0 none, 1 P, 2 ~P
    int wr_sel [6] = '{1, 2, 1, 2, 1, 0};

    int checks = 0;
    int errors = 0;
    exp_t sbq [$];

    task automatic mem_write(input int m, input int a, input logic [7:0] d);
        logic [7:0] v;
        v = d;
        if (fkind == 1 && a == f_addr) v[f_bit] = f_val[0];
        mem[m][a] = v;
        if (fkind == 2 && a == f_addr) mem[m][f_vic][f_bit] = ~mem[m][f_vic][f_bit];
    endtask

    function automatic logic [7:0] pat(input int sel, input logic [7:0] bg);
        return (sel == 2) ? ~bg : bg;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural RAMs with read latency 1 and 2.
    logic [7:0] rd1_q, rd2_a, rd2_b;
    initial forever begin
        @(posedge clk);
        rd1_q <= mem[0][bus1.ram_addr];
        rd2_a <= mem[1][bus2.ram_addr];
        rd2_b <= rd2_a;
        if (bus1.ram_we) mem_write(0, int'(bus1.ram_addr), bus1.ram_wdata);
        if (bus2.ram_we) mem_write(1, int'(bus2.ram_addr), bus2.ram_wdata);
    end
    assign bus1.ram_rdata = rd1_q;
    assign bus2.ram_rdata = rd2_b;

    // March C- walked over the model array with the currently configured fault.
    task automatic ref_run(input int lat, input logic [7:0] bg, output exp_t e);
        int cyc, a;
        cyc = 0;
        e = '0;
        e.pass = 1'b1;
        for (int el = 0; el < 6; el++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = (el >= 3) ? DEPTH - 1 - i : i;
                if (rd_sel[el] == 0) begin
                    mem_write(2, a, pat(wr_sel[el], bg));
                    cyc++;
                end else begin
                    cyc += lat + 1;
                    if (mem[2][a] !== pat(rd_sel[el], bg)) begin
                        e.pass = 1'b0;
                        e.fail = 1'b1;
                        e.addr = a[6:0];
                        e.data = mem[2][a];
                        e.elem = el[2:0];
                        e.cycles = cyc;
                        return;
                    end
                    if (wr_sel[el] != 0) mem_write(2, a, pat(wr_sel[el], bg));
                end
            end
        end
        e.cycles = cyc;
    endtask

    // Monitor: busy-cycle count, RAM-port idle rules, and scoreboard pop on done.
    int cyc_cnt = 0;
    initial forever begin
        exp_t e;
        logic gp, gf;
        logic [6:0] ga;
        logic [7:0] gd;
        logic [2:0] ge;
        @(negedge clk);
        if (!rst_n) begin
            cyc_cnt = 0;
        end else begin
            if (busy1 || busy2) cyc_cnt++;
            chk("ram_sel1", {31'd0, bus1.ram_sel}, {31'd0, busy1});
            chk("ram_sel2", {31'd0, bus2.ram_sel}, {31'd0, busy2});
            if (!busy1) chk("idle_port1", {bus1.ram_addr, bus1.ram_we, bus1.ram_wdata}, 0);
            if (!busy2) chk("idle_port2", {bus2.ram_addr, bus2.ram_we, bus2.ram_wdata}, 0);
            if (done1 || done2) begin
                gp = done1 ? pass1 : pass2;
                gf = done1 ? fail1 : fail2;
                ga = done1 ? fa1 : fa2;
                gd = done1 ? fd1 : fd2;
                ge = done1 ? fe1 : fe2;
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("pass", {31'd0, gp}, {31'd0, e.pass});
                    chk("fail", {31'd0, gf}, {31'd0, e.fail});
                    chk("busy_cycles", cyc_cnt, e.cycles);
                    if (e.fail) begin
                        chk("fail_addr", {25'd0, ga}, {25'd0, e.addr});
                        chk("fail_data", {24'd0, gd}, {24'd0, e.data});
                        chk("fail_elem", {29'd0, ge}, {29'd0, e.elem});
                    end
                end
                cyc_cnt = 0;
            end
        end
    end

    task automatic wait_drain(input int lim);
        for (int i = 0; i < lim && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            chk("timeout_waiting_done", sbq.size(), 0);
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int inst, input bit mid_pulse);
        exp_t e;
        int lat, nbad;
        logic [7:0] bg;
        lat = (inst == 0) ? 1 : 2;
        bg = (inst == 0) ? 8'h00 : 8'h5A;
        ref_run(lat, bg, e);
        sbq.push_back(e);
        if (inst == 0) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        if (inst == 0) begin
            chk("first_write1", {busy1, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata},
                {2'b11, 7'd0, bg});
        end else begin
            chk("first_write2", {busy2, bus2.ram_we, bus2.ram_addr, bus2.ram_wdata},
                {2'b11, 7'd0, bg});
        end
        if (mid_pulse) begin
            repeat (50) @(posedge clk);
            #1;
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
        end
        wait_drain(6000);
        if (e.pass) begin
            nbad = 0;
            for (int a = 0; a < DEPTH; a++) if (mem[inst][a] !== bg) nbad++;
            chk("ram_contents", nbad, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs1", {busy1, done1, pass1, fail1, fa1, fd1, fe1, bus1.ram_sel}, 0);
        chk("reset_outputs2", {busy2, done2, pass2, fail2, fa2, fd2, fe2, bus2.ram_sel}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fkind = 0;
        run(0, 1'b0);

        fkind = 1; f_addr = 'h2A; f_bit = 3; f_val = 1;
        run(0, 1'b0);

        fkind = 2; f_addr = 'h10; f_vic = 'h11; f_bit = 0;
        run(0, 1'b0);

        fkind = 0;
        run(1, 1'b0);

        // Reset in busy cycle 300: aborts silently.
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_state", {busy1, bus1.ram_we, done1}, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", {busy1, done1}, 0);
        run(0, 1'b0);

        run(0, 1'b1);

        // Start held high: two back-to-back runs with one IDLE cycle between.
        ref_run(1, 8'h00, e);
        sbq.push_back(e);
        sbq.push_back(e);
        start1 = 1'b1;
        n = 0;
        while (!done1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("held_first_done", {31'd0, done1}, 1);
        @(posedge clk);
        #1;
        chk("held_idle_gap", {busy1, done1}, 0);
        @(posedge clk);
        #1;
        chk("held_restart", {31'd0, busy1}, 1);
        start1 = 1'b0;
        wait_drain(3000);

        for (int it = 0; it < 8; it++) begin
            fkind = $urandom_range(0, 2);
            f_addr = $urandom_range(0, DEPTH - 1);
            f_vic = (f_addr + $urandom_range(1, DEPTH - 1)) % DEPTH;
            f_bit = $urandom_range(0, 7);
            f_val = $urandom_range(0, 1);
            run($urandom_range(0, 1), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
